// File: rtl/in_order_retire_pkg.sv
// -----------------------------------------------------------------------------
// in_order_retire_pkg
//   Types and defaults shared by the in-order retire block.
//   - state_e           : retire controller state (RUN / DRAIN)
//   - DEF_ENTRY_WIDTH   : default queue entry width
//   - DEF_DONE_BIT      : default "completed" bit position
//   - DEF_EXC_BIT       : default "raised exception" bit position
//   - default_done_bit / default_exc_bit : derive positions for any width
// -----------------------------------------------------------------------------
package in_order_retire_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  localparam int DEF_ENTRY_WIDTH = 32;
  localparam int DEF_DONE_BIT    = DEF_ENTRY_WIDTH - 1;
  localparam int DEF_EXC_BIT     = DEF_ENTRY_WIDTH - 2;

  // Status flags live in the two MSBs of an entry regardless of its width.
  function automatic int default_done_bit(input int entry_width);
    return entry_width - 1;
  endfunction

  function automatic int default_exc_bit(input int entry_width);
    return entry_width - 2;
  endfunction

endpackage

// File: rtl/in_order_retire_out_stage.sv
// -----------------------------------------------------------------------------
// retire_out_stage
//   Single-entry registered output of the retire block (valid/ready slice).
//   Ports:
//     clk_i       : clock, rising edge
//     rst_ni      : asynchronous active-low reset
//     load_i      : head popped for delivery; capture it this edge
//     load_data_i : entry to capture
//     load_exc_i  : exception flag of the entry to capture
//     clear_i     : discard any held entry (flush)
//     ready_i     : downstream accepts the held entry
//     valid_o     : held entry valid
//     data_o      : held entry
//     exc_o       : held entry carries an exception
// -----------------------------------------------------------------------------
module retire_out_stage #(
  parameter int ENTRY_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   load_i,
  input  logic [ENTRY_WIDTH-1:0] load_data_i,
  input  logic                   load_exc_i,
  input  logic                   clear_i,
  input  logic                   ready_i,
  output logic                   valid_o,
  output logic [ENTRY_WIDTH-1:0] data_o,
  output logic                   exc_o
);

  logic                   valid_q, valid_d;
  logic [ENTRY_WIDTH-1:0] data_q,  data_d;
  logic                   exc_q,   exc_d;

  // Clear wins over load; the controller never asserts both, but a flush must
  // never let a stale entry survive.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    exc_d   = exc_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = load_data_i;
      exc_d   = load_exc_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      exc_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      exc_q   <= exc_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign exc_o   = exc_q;

endmodule

// File: rtl/register.sv
// -----------------------------------------------------------------------------
// register
//   Plain D register with asynchronous active-low reset to RST_VAL.
//   Ports:
//     clk_i  : clock, rising edge
//     rst_ni : asynchronous active-low reset
//     d_i    : next value
//     q_o    : registered value
// -----------------------------------------------------------------------------
module register #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_o <= RST_VAL;
    else         q_o <= d_i;
  end

endmodule

// File: rtl/up_counter.sv
// -----------------------------------------------------------------------------
// up_counter
//   Free-running wrapping up-counter with enable, async active-low reset to 0.
//   Ports:
//     clk_i   : clock, rising edge
//     rst_ni  : asynchronous active-low reset
//     en_i    : increment by one on this edge
//     count_o : current count, wraps from 2^W-1 to 0
// -----------------------------------------------------------------------------
module up_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en_i) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/in_order_retire.sv
// -----------------------------------------------------------------------------
// in_order_retire
//   Retires completed entries from the head of an in-order queue, one per
//   cycle, into a registered output. An excepting entry or an external flush
//   switches to DRAIN, where remaining heads are popped and discarded.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   RUN   | pop done heads into the output register, stall on not-done head
//   DRAIN | pop and discard every head; back to RUN once queue and output empty
//
//   Ports:
//     clk          : clock, rising edge
//     rst_aL       : asynchronous active-low reset
//     head_valid   : queue head present
//     head_data    : queue head entry
//     head_ready   : pop the head this cycle
//     ret_valid    : retired entry valid (registered)
//     ret_data     : retired entry (registered)
//     ret_exc      : retired entry carries an exception
//     ret_ready    : downstream accepts ret_data
//     flush        : external flush pulse
//     draining     : state is DRAIN
//     retire_count : entries handed downstream (wrapping)
//     drain_count  : entries discarded by drains (wrapping)
// -----------------------------------------------------------------------------
module in_order_retire
  import in_order_retire_pkg::*;
#(
  parameter int ENTRY_WIDTH = DEF_ENTRY_WIDTH,
  parameter int DONE_BIT    = default_done_bit(ENTRY_WIDTH),
  parameter int EXC_BIT     = default_exc_bit(ENTRY_WIDTH),
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_aL,
  input  logic                   head_valid,
  input  logic [ENTRY_WIDTH-1:0] head_data,
  output logic                   head_ready,
  output logic                   ret_valid,
  output logic [ENTRY_WIDTH-1:0] ret_data,
  output logic                   ret_exc,
  input  logic                   ret_ready,
  input  logic                   flush,
  output logic                   draining,
  output logic [CNT_WIDTH-1:0]   retire_count,
  output logic [CNT_WIDTH-1:0]   drain_count
);

  state_e state_q, state_d;
  logic   state_raw;
  logic   in_run;
  logic   out_free;
  logic   pop_run;
  logic   pop_drain;
  logic   flush_run;

  register #(.W(1), .RST_VAL(1'b0)) u_state_reg (
    .clk_i  (clk),
    .rst_ni (rst_aL),
    .d_i    (state_d),
    .q_o    (state_raw)
  );

  assign state_q = state_e'(state_raw);
  assign in_run  = (state_q == RUN);

  // Output slot can take a new entry when empty or being emptied this cycle.
  assign out_free  = !ret_valid || ret_ready;
  assign head_ready = in_run ? (head_valid && head_data[DONE_BIT] && out_free && !flush)
                             : head_valid;
  assign pop_run   = in_run && head_ready;
  assign pop_drain = !in_run && head_valid;
  assign flush_run = in_run && flush;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (flush_run || (pop_run && head_data[EXC_BIT])) state_d = DRAIN;
      DRAIN:   if (!head_valid && !ret_valid)                    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  retire_out_stage #(.ENTRY_WIDTH(ENTRY_WIDTH)) u_out_stage (
    .clk_i       (clk),
    .rst_ni      (rst_aL),
    .load_i      (pop_run),
    .load_data_i (head_data),
    .load_exc_i  (head_data[EXC_BIT]),
    .clear_i     (flush_run),
    .ready_i     (ret_ready),
    .valid_o     (ret_valid),
    .data_o      (ret_data),
    .exc_o       (ret_exc)
  );

  // A flush that lands on a handshake cycle still counts that entry: it was
  // accepted downstream before being discarded.
  up_counter #(.W(CNT_WIDTH)) u_retire_cnt (
    .clk_i   (clk),
    .rst_ni  (rst_aL),
    .en_i    (ret_valid && ret_ready),
    .count_o (retire_count)
  );

  up_counter #(.W(CNT_WIDTH)) u_drain_cnt (
    .clk_i   (clk),
    .rst_ni  (rst_aL),
    .en_i    (pop_drain),
    .count_o (drain_count)
  );

  assign draining = (state_q == DRAIN);

endmodule
